// File: rtl/ram_scan_viewer.sv
// ram_scan_viewer: RAM with a user write port and a self-scanning registered read port.
// Ports: clk; reset (async, active-low); wr_en/wr_addr/wr_data write port;
// pause freezes auto-scan, step rising edge advances while paused;
// rd_addr/rd_data show the scanned word, rd_valid pulses when rd_addr takes a new address.
// Define RAM_SCAN_WRITE_THROUGH_EN to bypass a write to the viewed address onto rd_data.
module ram_scan_viewer #(
  parameter int DATA_W = 3,
  parameter int ADDR_W = 5,
  parameter int SCAN_TICKS = 50_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pause,
  input  logic              step,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid
);
  localparam int CNT_W = SCAN_TICKS > 1 ? $clog2(SCAN_TICKS) : 1;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [ADDR_W-1:0] scan_addr;
  logic [CNT_W-1:0] tick_cnt;
  logic step_q, adv_q, adv;
  logic [DATA_W-1:0] rd_next;
  assign adv = pause ? step & ~step_q : tick_cnt == CNT_W'(SCAN_TICKS - 1);
`ifdef RAM_SCAN_WRITE_THROUGH_EN
  assign rd_next = wr_en && wr_addr == scan_addr ? wr_data : mem[scan_addr];
`else
  assign rd_next = mem[scan_addr];
`endif
  always_ff @(posedge clk)
    if (wr_en) mem[wr_addr] <= wr_data;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      scan_addr <= '0;
      tick_cnt <= '0;
      step_q <= 1'b0;
      adv_q <= 1'b0;
      rd_addr <= '0;
      rd_data <= '0;
      rd_valid <= 1'b0;
    end else begin
      tick_cnt <= adv || pause ? '0 : tick_cnt + 1'b1;
      scan_addr <= scan_addr + ADDR_W'(adv);
      step_q <= step;
      adv_q <= adv;
      rd_valid <= adv_q;
      rd_addr <= scan_addr;
      rd_data <= rd_next;
    end
endmodule

// File: tb/tb_ram_scan_viewer.sv
// tb_ram_scan_viewer: randomized self-checking bench for ram_scan_viewer (DATA_W=4, ADDR_W=3, SCAN_TICKS=4).
module tb_ram_scan_viewer;
  localparam int DW = 4, AW = 3, ST = 4, DEPTH = 8;
  logic clk = 0, reset = 1, wr_en, pause, step;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data, rd_data;
  logic rd_valid;
  int checks = 0, failures = 0, cur = 0;
  logic [DW-1:0] mm [DEPTH];

  ram_scan_viewer #(.DATA_W(DW), .ADDR_W(AW), .SCAN_TICKS(ST)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .pause(pause), .step(step), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic write(input int a, input logic [DW-1:0] d);
    wr_en = 1; wr_addr = AW'(a); wr_data = d;
    tick;
    wr_en = 0;
    mm[a] = d;
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk);
    #3 reset = 0;
    #1;
    checks++;
    if ({rd_addr, rd_data, rd_valid} !== '0) begin
      failures++;
      $display("FAIL %s_async_zero got=%0h/%0h/%0b exp=0/0/0", tag, rd_addr, rd_data, rd_valid);
    end
    pause = 1; step = 0;
    #3 reset = 1;
    cur = 0;
    tick;
    checks++;
    if (rd_addr !== 0 || rd_data !== mm[0] || rd_valid !== 0) begin
      failures++;
      $display("FAIL %s_first_edge got=%0h/%0h/%0b exp=0/%0h/0", tag, rd_addr, rd_data, rd_valid, mm[0]);
    end
  endtask

  task automatic step_pulse(input int hold);
    int n = 0;
    step = 1;
    repeat (hold) begin tick; n += int'(rd_valid); end
    step = 0;
    repeat (3) begin tick; n += int'(rd_valid); end
    cur = (cur + 1) % DEPTH;
    checks += 3;
    if (n !== 1) begin failures++; $display("FAIL step_valid_pulses got=%0d exp=1", n); end
    if (rd_addr !== AW'(cur)) begin failures++; $display("FAIL step_addr got=%0d exp=%0d", rd_addr, cur); end
    if (rd_data !== mm[cur]) begin failures++; $display("FAIL step_data got=%0h exp=%0h", rd_data, mm[cur]); end
  endtask

  task automatic run_free(input int n);
    int start = cur, ea;
    logic ev;
    pause = 0;
    for (int c = 1; c <= n; c++) begin
      step = 1'($urandom);
      tick;
      ea = (start + (c - 1) / ST) % DEPTH;
      ev = c > ST && (c - 1) % ST == 0;
      checks += 3;
      if (rd_addr !== AW'(ea)) begin failures++; $display("FAIL free_addr c=%0d got=%0d exp=%0d", c, rd_addr, ea); end
      if (rd_valid !== ev) begin failures++; $display("FAIL free_valid c=%0d got=%0b exp=%0b", c, rd_valid, ev); end
      if (rd_data !== mm[ea]) begin failures++; $display("FAIL free_data c=%0d got=%0h exp=%0h", c, rd_data, mm[ea]); end
    end
    step = 0; pause = 1;
    cur = (start + n / ST) % DEPTH;
  endtask

  task automatic test_reset;
    do_reset("reset");
    repeat (9) begin
      tick;
      checks++;
      if (rd_addr !== 0 || rd_valid !== 0) begin
        failures++;
        $display("FAIL reset_hold got=%0d/%0b exp=0/0", rd_addr, rd_valid);
      end
    end
  endtask

  task automatic test_manual_step;
    write(1, 4'hA);
    write(2, 4'h5);
    step_pulse(1);
    step_pulse(1);
    step_pulse(10);
  endtask

  task automatic test_free_run;
    run_free(38);
  endtask

  task automatic test_pause_resume;
    for (int i = 0; i < 20; i++) begin
      step = 1'($urandom % 2 == 0 && i < 2 ? 0 : 0);
      tick;
      checks++;
      if (rd_valid !== 0 || rd_addr !== AW'(cur)) begin
        failures++;
        $display("FAIL paused_hold got=%0d/%0b exp=%0d/0", rd_addr, rd_valid, cur);
      end
    end
    run_free(14);
    repeat (3) tick;
  endtask

  task automatic test_write_view;
    logic [DW-1:0] old;
    while (cur != 3) step_pulse(1);
    old = mm[3];
    wr_en = 1; wr_addr = 3; wr_data = 4'hC;
    tick;
    wr_en = 0;
    checks++;
`ifdef RAM_SCAN_WRITE_THROUGH_EN
    if (rd_data !== 4'hC) begin failures++; $display("FAIL wt_edge_T got=%0h exp=c", rd_data); end
`else
    if (rd_data !== old) begin failures++; $display("FAIL wt_edge_T got=%0h exp=%0h", rd_data, old); end
`endif
    tick;
    mm[3] = 4'hC;
    checks++;
    if (rd_data !== 4'hC) begin failures++; $display("FAIL wt_edge_T1 got=%0h exp=c", rd_data); end
    repeat (2) tick;
  endtask

  task automatic test_back_to_back;
    logic ps = 0, pa = 0, ev;
    logic [DW-1:0] ed;
    logic [AW-1:0] ea;
    for (int i = 0; i < 40; i++) begin
      wr_en = 1'($urandom);
      wr_addr = AW'($urandom);
      if (wr_addr == 1) wr_addr = 0;
      wr_data = DW'($urandom);
      step = $urandom_range(0, 2) == 0;
      ea = AW'(cur); ev = pa; ed = mm[cur];
`ifdef RAM_SCAN_WRITE_THROUGH_EN
      if (wr_en && wr_addr == ea) ed = wr_data;
`endif
      tick;
      checks += 3;
      if (rd_addr !== ea) begin failures++; $display("FAIL b2b_addr i=%0d got=%0d exp=%0d", i, rd_addr, ea); end
      if (rd_valid !== ev) begin failures++; $display("FAIL b2b_valid i=%0d got=%0b exp=%0b", i, rd_valid, ev); end
      if (rd_data !== ed) begin failures++; $display("FAIL b2b_data i=%0d got=%0h exp=%0h", i, rd_data, ed); end
      if (wr_en) mm[wr_addr] = wr_data;
      pa = step & ~ps;
      ps = step;
      if (pa) cur = (cur + 1) % DEPTH;
    end
    wr_en = 0; step = 0;
    repeat (3) tick;
  endtask

  task automatic test_reset_mid_run;
    int k = (5 - cur + DEPTH) % DEPTH;
    if (k == 0) k = DEPTH;
    run_free(ST * k + 1);
    do_reset("midrun");
    step_pulse(1);
    checks++;
    if (rd_data !== 4'hA) begin failures++; $display("FAIL midrun_retained got=%0h exp=a", rd_data); end
  endtask

  initial begin
    pause = 1; step = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
    #1 reset = 0;
    #1;
    checks++;
    if ({rd_addr, rd_data, rd_valid} !== '0) begin
      failures++;
      $display("FAIL por_zero got=%0h/%0h/%0b exp=0/0/0", rd_addr, rd_data, rd_valid);
    end
    #1 reset = 1;
    for (int a = 0; a < DEPTH; a++)
      write(a, a == 0 ? DW'($urandom_range(1, 15)) : a == 3 ? DW'($urandom_range(0, 11)) : DW'($urandom));
    test_reset;
    test_manual_step;
    test_free_run;
    test_pause_resume;
    test_write_view;
    test_back_to_back;
    test_reset_mid_run;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
